adder16_arbiter: RTL and testbench
==================================

Name: adder16_arbiter

Overview:
- Shares one 16-bit ripple-carry adder (adder16_fa, carry-in fixed 0) between two requesters.
- Arbitration is round-robin.
- Operands are registered before they reach the adder. A programmable number of settle cycles is allowed for the ripple chain, then sum and carry are registered and returned with the requester ID.
- Sits between the two client datapaths and the single adder instance. The adder is instantiated inside this block.

Parameters:
- ADD_LATENCY, 1, settle cycles between operand capture and result capture; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has operands
- req0_a  input  16  requester 0 operand A
- req0_b  input  16  requester 0 operand B
- req0_ready  output  1  requester 0 operands accepted this cycle
- req1_valid  input  1  requester 1 has operands
- req1_a  input  16  requester 1 operand A
- req1_b  input  16  requester 1 operand B
- req1_ready  output  1  requester 1 operands accepted this cycle
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  requester that owns rsp_sum
- rsp_sum  output  16  registered sum (a+b) mod 2^16
- rsp_cout  output  1  registered carry out of bit 15
- op_count  output  16  completed-operation counter

Behaviour:
- Single clock. All state changes on rising clk.
- Reset: synchronous, active-high, overrides everything including an in-flight operation.
  - State goes to IDLE.
  - rsp_valid, rsp_id, rsp_sum, rsp_cout and op_count reset to 0.
  - Internal op_a/op_b reset to 0.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - An in-flight operation is discarded; no response is produced for it.
- States: IDLE, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational: high only in IDLE, only for the granted requester, and only while that requester's valid is high.
  - Grant rules:
    - Only one valid: grant it.
    - Both valid: grant the requester that is not last_grant.
    - Neither valid: no grant, stay in IDLE.
  - On a transfer (valid & ready):
    - Capture reqN_a/b into op_a/op_b.
    - Record the winner in id_r and last_grant.
    - Load settle counter with ADD_LATENCY.
    - Go to WAIT.
- WAIT:
  - Both ready outputs are low.
  - Counter decrements each cycle.
  - In the cycle the counter equals 1:
    - Register the adder outputs into rsp_sum/rsp_cout, and id_r into rsp_id.
    - Increment op_count, wrapping FFFF to 0000.
    - Go to RESP.
  - WAIT lasts exactly ADD_LATENCY cycles.
- RESP:
  - rsp_valid is high. rsp_sum, rsp_cout and rsp_id are held stable until the handshake.
  - On rsp_ready: rsp_valid clears next cycle and the state returns to IDLE. No new request is accepted in the same cycle as the response handshake.
  - rsp_sum, rsp_cout and rsp_id keep their last values after rsp_valid drops.
- Latency:
  - Request accept edge E0.
  - rsp_valid first high in the cycle after edge E0+ADD_LATENCY.
  - Minimum issue interval is ADD_LATENCY+2 cycles when rsp_ready is held high.
- Arithmetic:
  - Unsigned 16-bit add, carry-in 0.
  - rsp_cout = bit 16 of the 17-bit sum.
  - No saturation.
- Requesters must hold valid and operands stable until ready. A valid that drops without a ready has no effect.
- Non-granted requesters are never blocked forever. With both valid continuously, grants strictly alternate.
- rsp_ready asserted outside RESP is ignored.

Test Plan:
- Reset, then req0 only, a=0x1234, b=0x0FF0, ADD_LATENCY=1, rsp_ready=1 -> req0_ready on accept cycle; rsp_valid 2 cycles after accept edge; rsp_sum=0x2224, rsp_cout=0, rsp_id=0, op_count=1.
- Overflow: req1 a=0xFFFF, b=0x0001 -> rsp_sum=0x0000, rsp_cout=1, rsp_id=1. Then a=0x8000, b=0x8000 -> sum 0x0000, cout 1.
- Both valid continuously for 4 operations from reset -> rsp_id sequence 0,1,0,1; the non-granted ready stays low each time.
- Backpressure: rsp_ready held low 5 cycles in RESP -> rsp_valid and result stable all 5 cycles, no req ready asserted; ready resumes 1 cycle after the handshake.
- ADD_LATENCY=4 -> WAIT lasts exactly 4 cycles (counter 4,3,2,1); result matches the operands captured at accept even if the requester changes its operands after ready.
- rst asserted in WAIT -> next cycle IDLE, rsp_valid=0, op_count=0, no response emitted. Also preload op_count=0xFFFF, complete one op -> op_count wraps to 0x0000.

Source files
------------

// File: rtl/adder16_arbiter.sv
// Round-robin sharing of one 16-bit ripple-carry adder between two requesters.
// Operands are registered, given ADD_LATENCY settle cycles, then the result is registered.

module adder16_fa (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[16];

endmodule

module adder16_arbiter #(
  parameter int unsigned ADD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_sum,
  output logic        rsp_cout,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic        id_q, id_d;
  logic        last_q, last_d;
  logic [15:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        rid_q, rid_d;
  logic [15:0] op_count_q, op_count_d;
  logic        gnt0, gnt1;
  logic [15:0] add_sum;
  logic        add_cout;

  adder16_fa u_add (
    .a    (op_a_q),
    .b    (op_b_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // last_q == 1 means requester 1 won last, so requester 0 wins a tie.
  assign gnt0 = req0_valid & (~req1_valid | last_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      id_q       <= 1'b0;
      last_q     <= 1'b1;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      rid_q      <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      id_q       <= id_d;
      last_q     <= last_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      rid_q      <= rid_d;
      op_count_q <= op_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    id_d       = id_q;
    last_d     = last_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    rid_d      = rid_q;
    op_count_d = op_count_q;
    unique case (state_q)
      StIdle: begin
        if (gnt0 | gnt1) begin
          op_a_d  = gnt1 ? req1_a : req0_a;
          op_b_d  = gnt1 ? req1_b : req0_b;
          id_d    = gnt1;
          last_d  = gnt1;
          cnt_d   = 4'(ADD_LATENCY);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd1) begin
          sum_d      = add_sum;
          cout_d     = add_cout;
          rid_d      = id_q;
          op_count_d = op_count_q + 16'd1;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == StIdle) begin
      req0_ready = gnt0;
      req1_ready = gnt1;
    end
    rsp_valid = (state_q == StResp);
  end

  assign rsp_id   = rid_q;
  assign rsp_sum  = sum_q;
  assign rsp_cout = cout_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_adder16_arbiter.sv
// Randomized bench for adder16_arbiter: two instances (settle 1 and 4) share stimulus,
// outputs of the active one are compared against a transaction-level model.

module tb_adder16_arbiter;

  localparam int unsigned LatA = 1;
  localparam int unsigned LatB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;

  logic        r0_a, r1_a, v_a, id_a, co_a;
  logic [15:0] s_a, c_a;
  logic        r0_b, r1_b, v_b, id_b, co_b;
  logic [15:0] s_b, c_b;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout;
  logic [15:0] rsp_sum, op_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          lat;
  logic        m_last;
  logic [15:0] m_count, m_sum;
  logic        m_cout, m_id;

  always #5 clk = ~clk;

  adder16_arbiter #(.ADD_LATENCY(LatA)) u_dut_l1 (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (r0_a),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (r1_a),
    .rsp_valid  (v_a),
    .rsp_ready  (rsp_ready),
    .rsp_id     (id_a),
    .rsp_sum    (s_a),
    .rsp_cout   (co_a),
    .op_count   (c_a)
  );

  adder16_arbiter #(.ADD_LATENCY(LatB)) u_dut_l4 (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (r0_b),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (r1_b),
    .rsp_valid  (v_b),
    .rsp_ready  (rsp_ready),
    .rsp_id     (id_b),
    .rsp_sum    (s_b),
    .rsp_cout   (co_b),
    .op_count   (c_b)
  );

  assign req0_ready = sel ? r0_b : r0_a;
  assign req1_ready = sel ? r1_b : r1_a;
  assign rsp_valid  = sel ? v_b : v_a;
  assign rsp_id     = sel ? id_b : id_a;
  assign rsp_sum    = sel ? s_b : s_a;
  assign rsp_cout   = sel ? co_b : co_a;
  assign op_count   = sel ? c_b : c_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (lat %0d): got %0h expected %0h", tag, lat, got, exp);
  endtask

  // Round-robin expectation as {ready1, ready0}.
  function automatic logic [1:0] exp_ready(input logic v0, input logic v1);
    if (v0 && v1) return m_last ? 2'b01 : 2'b10;
    return {v1, v0};
  endfunction

  function automatic logic [15:0] rnd();
    logic [15:0] c [4] = '{16'h0000, 16'hffff, 16'h8000, 16'h0001};
    if ($urandom_range(0, 3) == 0) return c[2'($urandom_range(0, 3))];
    return 16'($urandom);
  endfunction

  task automatic check_rsp(input string tag, input logic exp_valid);
    check({tag, ".valid"}, 32'(rsp_valid), 32'(exp_valid));
    check({tag, ".sum"}, 32'(rsp_sum), 32'(m_sum));
    check({tag, ".cout"}, 32'(rsp_cout), 32'(m_cout));
    check({tag, ".id"}, 32'(rsp_id), 32'(m_id));
    check({tag, ".count"}, 32'(op_count), 32'(m_count));
  endtask

  task automatic check_ready(input string tag, input logic [1:0] er);
    check({tag, ".ready0"}, 32'(req0_ready), 32'(er[0]));
    check({tag, ".ready1"}, 32'(req1_ready), 32'(er[1]));
  endtask

  task automatic model_reset();
    m_last  = 1'b1;
    m_count = '0;
    m_sum   = '0;
    m_cout  = 1'b0;
    m_id    = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_rsp("reset", 1'b0);
    check_ready("reset", 2'b00);
  endtask

  // One full transaction starting in IDLE at a falling edge; hold = RESP backpressure cycles.
  task automatic run_op(input logic v0, input logic v1, input logic [15:0] a0,
                        input logic [15:0] b0, input logic [15:0] a1, input logic [15:0] b1,
                        input int hold);
    logic [1:0]  er;
    logic        w;
    logic [16:0] full;
    req0_valid = v0;
    req1_valid = v1;
    req0_a     = a0;
    req0_b     = b0;
    req1_a     = a1;
    req1_b     = b1;
    rsp_ready  = 1'($urandom_range(0, 1));
    er = exp_ready(v0, v1);
    #1;
    check_ready("accept", er);
    w    = er[1];
    full = w ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
    @(posedge clk);
    m_last = w;
    @(negedge clk);
    // Winner changes its operands after the handshake; the result must not follow.
    if (w) begin
      req1_a = 16'($urandom);
      req1_b = 16'($urandom);
    end else begin
      req0_a = 16'($urandom);
      req0_b = 16'($urandom);
    end
    for (int k = 0; k < lat; k++) begin
      if (w) req1_valid = 1'($urandom_range(0, 1));
      else   req0_valid = 1'($urandom_range(0, 1));
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      check_rsp("wait", 1'b0);
      check_ready("wait", 2'b00);
      @(negedge clk);
    end
    m_count = m_count + 16'd1;
    m_sum   = full[15:0];
    m_cout  = full[16];
    m_id    = w;
    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      #1;
      check_rsp("resp_hold", 1'b1);
      check_ready("resp_hold", 2'b00);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check_rsp("resp_hs", 1'b1);
    check_ready("resp_hs", 2'b00);
    @(negedge clk);
    rsp_ready = 1'b0;
    er = exp_ready(req0_valid, req1_valid);
    #1;
    check_rsp("post", 1'b0);
    check_ready("post", er);
  endtask

  task automatic rand_op();
    logic [1:0] p;
    p = 2'($urandom_range(1, 3));
    run_op(p[0], p[1], rnd(), rnd(), rnd(), rnd(), int'($urandom_range(0, 3)));
  endtask

  task automatic idle_test();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      check_rsp("idle", 1'b0);
      check_ready("idle", 2'b00);
      @(negedge clk);
    end
  endtask

  task automatic reset_in_wait();
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    req0_a     = 16'h5555;
    req0_b     = 16'haaaa;
    #1;
    check_ready("rw.accept", exp_ready(1'b1, 1'b0));
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_rsp("rw.after", 1'b0);
    for (int k = 0; k < lat + 2; k++) begin
      @(negedge clk);
      #1;
      check_rsp("rw.quiet", 1'b0);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_ready("rw.tie", 2'b01);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    sel    = 1'b0;
    lat    = int'(LatA);
    req0_a = '0;
    req0_b = '0;
    req1_a = '0;
    req1_b = '0;
    do_reset();

    run_op(1'b1, 1'b0, 16'h1234, 16'h0ff0, 16'h0000, 16'h0000, 0);
    check("t1.sum", 32'(rsp_sum), 32'h2224);
    check("t1.cout", 32'(rsp_cout), 32'h0);
    check("t1.id", 32'(rsp_id), 32'h0);
    check("t1.count", 32'(op_count), 32'h1);
    run_op(1'b0, 1'b1, 16'h0000, 16'h0000, 16'hffff, 16'h0001, 0);
    check("ovf1.sum", 32'(rsp_sum), 32'h0);
    check("ovf1.cout", 32'(rsp_cout), 32'h1);
    check("ovf1.id", 32'(rsp_id), 32'h1);
    run_op(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 0);
    check("ovf2.sum", 32'(rsp_sum), 32'h0);
    check("ovf2.cout", 32'(rsp_cout), 32'h1);

    do_reset();
    req0_a = rnd();
    req0_b = rnd();
    req1_a = rnd();
    req1_b = rnd();
    for (int k = 0; k < 4; k++) begin
      run_op(1'b1, 1'b1, req0_a, req0_b, req1_a, req1_b, 0);
      check("alt.id", 32'(rsp_id), 32'(k % 2));
    end

    run_op(1'b1, 1'b0, rnd(), rnd(), rnd(), rnd(), 5);
    idle_test();
    for (int k = 0; k < 60; k++) rand_op();
    reset_in_wait();

    sel = 1'b1;
    lat = int'(LatB);
    do_reset();
    run_op(1'b1, 1'b1, rnd(), rnd(), rnd(), rnd(), 2);
    for (int k = 0; k < 60; k++) rand_op();
    idle_test();
    reset_in_wait();

    force u_dut_l4.op_count_q = 16'hffff;
    #1;
    release u_dut_l4.op_count_q;
    m_count = 16'hffff;
    #1;
    check("preload.count", 32'(op_count), 32'hffff);
    run_op(1'b1, 1'b0, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 0);
    check("wrap.count", 32'(op_count), 32'h0);
    check("wrap.sum", 32'(rsp_sum), 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
